// File: rtl/half_sub_pkg.sv
// Shared defaults for the registered lane-parallel half subtractor.
// Optional borrow statistics are enabled with the HALF_SUB_STATS_EN macro.
package half_sub_pkg;

    localparam int unsigned WIDTH_DEF = 1;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned CNT_MAX   = (1 << CNT_W_DEF) - 1;

endpackage

// File: rtl/half_sub_if.sv
// Operand/result bundle for half_subtractor; borrow_count exists only when
// HALF_SUB_STATS_EN is defined.
interface half_sub_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
);

    logic             in_valid;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] borrow;
`ifdef HALF_SUB_STATS_EN
    logic [CNT_W-1:0] borrow_count;
`endif

    modport master (
        output in_valid, in_1, in_2,
        input  out_valid, sum, borrow
`ifdef HALF_SUB_STATS_EN
        , input borrow_count
`endif
    );

    modport slave (
        input  in_valid, in_1, in_2,
        output out_valid, sum, borrow
`ifdef HALF_SUB_STATS_EN
        , output borrow_count
`endif
    );

endinterface

// File: rtl/half_sub_cell.sv
// Combinational single-lane half subtractor: d = a - b, bo = borrow out.
module half_sub_cell (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);

    assign d  = a ^ b;
    assign bo = ~a & b;

endmodule

// File: rtl/half_subtractor.sv
// Registered lane-parallel half subtractor with 1-cycle latency.
// Define HALF_SUB_STATS_EN to add the saturating borrow-event counter.
module half_subtractor
    import half_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic     clk,
    input logic     rst,
    half_sub_if.slave bus
);

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bo;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] borrow_q;
    logic             out_valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_sub_cell u_cell (
            .a  (bus.in_1[i]),
            .b  (bus.in_2[i]),
            .d  (diff[i]),
            .bo (bo[i])
        );
    end

    // Results hold while idle; only out_valid tracks in_valid every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            borrow_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q    <= diff;
                borrow_q <= bo;
            end
        end
    end

    assign bus.sum       = sum_q;
    assign bus.borrow    = borrow_q;
    assign bus.out_valid = out_valid_q;

`ifdef HALF_SUB_STATS_EN
    logic [CNT_W-1:0] borrow_count_q;

    // One event per valid cycle with any lane borrowing; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            borrow_count_q <= '0;
        end else if (bus.in_valid && (|bo) && !(&borrow_count_q)) begin
            borrow_count_q <= borrow_count_q + 1'b1;
        end
    end

    assign bus.borrow_count = borrow_count_q;
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench for half_subtractor (WIDTH=4, CNT_W=2), with a vector
// table, a result scoreboard queue and hand sequences for reset and hold.
module tb_half_subtractor;

    localparam int unsigned W = 4;
    localparam int unsigned CW = 2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] es;
        logic [W-1:0] eb;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] b;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    half_sub_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    half_subtractor #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    res_t sb_q[$];
    res_t held;
    logic exp_ov;
    int exp_cnt;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; expected result (es/eb) is queued when the input is accepted.
    task automatic step(input logic r, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] es,
                        input logic [W-1:0] eb);
        res_t e;
        rst = r;
        bus.in_valid = v;
        bus.in_1 = a;
        bus.in_2 = b;
        if (!r && v) begin
            e.s = es;
            e.b = eb;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            held.s = '0;
            held.b = '0;
            exp_ov = 1'b0;
            exp_cnt = 0;
        end else begin
            exp_ov = v;
            if (v && eb != '0 && exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
        if (exp_ov) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard: queue empty, expected a result");
            end else begin
                held = sb_q.pop_front();
            end
        end
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("sum", 32'(bus.sum), 32'(held.s));
        chk("borrow", 32'(bus.borrow), 32'(held.b));
`ifdef HALF_SUB_STATS_EN
        chk("borrow_count", 32'(bus.borrow_count), 32'(exp_cnt));
`endif
    endtask

    initial begin
        vecs[0] = '{a: 4'b0000, b: 4'b0000, es: 4'b0000, eb: 4'b0000};
        vecs[1] = '{a: 4'b0000, b: 4'b1111, es: 4'b1111, eb: 4'b1111};
        vecs[2] = '{a: 4'b1111, b: 4'b0000, es: 4'b1111, eb: 4'b0000};
        vecs[3] = '{a: 4'b1111, b: 4'b1111, es: 4'b0000, eb: 4'b0000};
        vecs[4] = '{a: 4'b0101, b: 4'b0011, es: 4'b0110, eb: 4'b0010};
        vecs[5] = '{a: 4'b1100, b: 4'b1010, es: 4'b0110, eb: 4'b0010};
        vecs[6] = '{a: 4'b0011, b: 4'b1100, es: 4'b1111, eb: 4'b1100};
        vecs[7] = '{a: 4'b1001, b: 4'b0110, es: 4'b1111, eb: 4'b0110};

        held.s = '0;
        held.b = '0;
        exp_ov = 1'b0;
        exp_cnt = 0;

        // Reset held two cycles with a valid 11 input that must be dropped.
        step(1'b1, 1'b1, 4'hf, 4'hf, 4'h0, 4'h0);
        step(1'b1, 1'b1, 4'hf, 4'hf, 4'h0, 4'h0);

        // Truth table and lane independence, back to back.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].es, vecs[i].eb);
        end

        // Hold: a 0/1 result must persist across idle cycles with junk inputs.
        step(1'b0, 1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'b1111, 4'b0000, 4'h0, 4'h0);
        end

        // Statistics: count saturates at 3; non-borrowing samples leave it alone.
        step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        end

        // Mid-stream reset between 01 and 10 inputs.
        step(1'b0, 1'b1, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        step(1'b1, 1'b1, 4'b0001, 4'b0000, 4'h0, 4'h0);
        step(1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        step(1'b0, 1'b0, 4'b0000, 4'b0000, 4'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
